vrf_bram2axi_store: RTL and testbench

- VRF store engine; sits directly downstream of the memory-access controller's VRF store interface.
- On a start pulse it reads 512-bit vector-register words from VRF BRAM and writes them to DDR4 as AXI4 INCR write bursts.
- Pulses done once every burst has received its write response.
- Mirror of the VRF AXI2BRAM load engine.

---
 rtl/ma_pkg.sv | 36 +++
 rtl/ma_sync_fifo.sv | 67 ++++++
 rtl/vrf_bram2axi_store.sv | 231 +++++++++++++++++++++++
 tb/tb_vrf_bram2axi_store.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ma_pkg.sv
`default_nettype none
// ============================================================================
// ma_pkg : shared constants, state encoding and burst-sizing helper for the
//          VRF BRAM<->AXI load/store engines.
// Revision: 1.0
// ============================================================================
package ma_pkg;

    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [2:0] SIZE_64B     = 3'b110;
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    localparam int BEAT_BYTES   = 64;
    localparam int BOUNDARY_4K  = 4096;
    localparam int BEATS_PER_4K = BOUNDARY_4K / BEAT_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_AW     = 3'd2,
        ST_DATA   = 3'd3,
        ST_RESP   = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // Beats left before the next 4 KB page bounds the burst; the page holds
    // exactly 64 beats, which also enforces the 64-beat burst ceiling.
    function automatic logic [6:0] burst_beats(input logic [8:0] rem,
                                               input logic [5:0] blk_off);
        logic [8:0] room;
        room = 9'(BEATS_PER_4K) - {3'b000, blk_off};
        return (rem < room) ? rem[6:0] : room[6:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ma_sync_fifo.sv
`default_nettype none
// ============================================================================
// ma_sync_fifo : single-clock FIFO with push/pop, full/empty and occupancy.
// Revision: 1.0
// ============================================================================
module ma_sync_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Pushes into a full FIFO and pops from an empty one are dropped.
    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vrf_bram2axi_store.sv
`default_nettype none
// ============================================================================
// vrf_bram2axi_store : streams VRF BRAM words to DDR as 4 KB-safe AXI4 INCR
//                      write bursts, one burst outstanding at a time.
// Revision: 1.0
// ============================================================================
module vrf_bram2axi_store
    import ma_pkg::*;
#(
    parameter int AXI_ADDR_W  = 36,
    parameter int DATA_W      = 512,
    parameter int BRAM_ADDR_W = 10,
    parameter int BRAM_RD_LAT = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BRAM_ADDR_W-1:0]  src_bram_addr,
    input  logic [AXI_ADDR_W-1:0]   dst_axi_addr,
    input  logic [14:0]             byte_to_transfer,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    bram_en,
    output logic [BRAM_ADDR_W-1:0]  bram_addr,
    input  logic [DATA_W-1:0]       bram_dout,
    output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_W-1:0]       m_axi_wdata,
    output logic [DATA_W/8-1:0]     m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    state_t                 state_q, state_d;
    logic [BRAM_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [AXI_ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [14:0]            btt_q, btt_d;
    logic [8:0]             rem_q, rem_d;
    logic [7:0]             awlen_q, awlen_d;
    logic [7:0]             issued_q, issued_d;
    logic [7:0]             wbeat_q, wbeat_d;
    logic                   err_q, err_d;
    logic [BRAM_RD_LAT-1:0] rd_vld_q;

    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [CNT_W-1:0]       w_fifo_count;
    logic [DATA_W-1:0]      w_fifo_head;
    logic [OCC_W-1:0]       w_inflight;
    logic [OCC_W-1:0]       w_occupancy;
    logic                   w_issue;
    logic                   w_pop;
    logic [8:0]             w_burst;
    logic [8:0]             w_rem_next;

    ma_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rd_vld_q[BRAM_RD_LAT-1]),
        .din_i   (bram_dout),
        .pop_i   (w_pop),
        .dout_o  (w_fifo_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    assign busy          = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign done          = (state_q == ST_FINISH);
    assign err           = err_q;
    assign bram_addr     = rd_addr_q;
    assign bram_en       = w_issue;
    assign m_axi_awaddr  = cur_addr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = SIZE_64B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awvalid = (state_q == ST_AW);
    assign m_axi_wdata   = w_fifo_head;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = (state_q == ST_DATA) && !w_fifo_empty;
    assign m_axi_wlast   = m_axi_wvalid && (wbeat_q == awlen_q);
    assign m_axi_bready  = (state_q == ST_RESP);
    assign w_pop         = m_axi_wvalid && m_axi_wready;

    assign w_burst    = {1'b0, awlen_q} + 9'd1;
    assign w_rem_next = rem_q - w_burst;

    // Reads still in the BRAM pipeline count against FIFO space so that the
    // data they return always has a slot waiting, whatever wready does.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < BRAM_RD_LAT; i++) begin
            w_inflight = w_inflight + OCC_W'(rd_vld_q[i]);
        end
        w_occupancy = OCC_W'(w_fifo_count) + w_inflight;
        w_issue     = ((state_q == ST_AW) || (state_q == ST_DATA))
                      && (issued_q <= awlen_q)
                      && (w_occupancy < OCC_W'(FIFO_DEPTH))
                      && !w_fifo_full;
    end

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        cur_addr_d = cur_addr_q;
        btt_d      = btt_q;
        rem_d      = rem_q;
        awlen_d    = awlen_q;
        issued_d   = issued_q;
        wbeat_d    = wbeat_q;
        err_d      = err_q;

        if (w_issue) begin
            rd_addr_d = rd_addr_q + BRAM_ADDR_W'(1);
            issued_d  = issued_q + 8'd1;
        end

        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    rd_addr_d  = src_bram_addr;
                    cur_addr_d = dst_axi_addr;
                    btt_d      = byte_to_transfer;
                    err_d      = 1'b0;
                    state_d    = ST_CHECK;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (btt_q == '0) begin
                    state_d = ST_FINISH;
                end else if ((btt_q[5:0] != '0) || (cur_addr_q[5:0] != '0)) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    rem_d    = btt_q[14:6];
                    awlen_d  = {1'b0, burst_beats(btt_q[14:6], cur_addr_q[11:6])} - 8'd1;
                    issued_d = '0;
                    wbeat_d  = '0;
                    state_d  = ST_AW;
                end
            end
            ST_AW: begin
                if (m_axi_awready) begin
                    cur_addr_d = cur_addr_q + AXI_ADDR_W'({w_burst, 6'b000000});
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_pop) begin
                    wbeat_d = wbeat_q + 8'd1;
                    if (m_axi_wlast) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    rem_d = w_rem_next;
                    if (w_rem_next != '0) begin
                        awlen_d  = {1'b0, burst_beats(w_rem_next, cur_addr_q[11:6])} - 8'd1;
                        issued_d = '0;
                        wbeat_d  = '0;
                        state_d  = ST_AW;
                    end else begin
                        state_d  = ST_FINISH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= '0;
            cur_addr_q <= '0;
            btt_q      <= '0;
            rem_q      <= '0;
            awlen_q    <= '0;
            issued_q   <= '0;
            wbeat_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            cur_addr_q <= cur_addr_d;
            btt_q      <= btt_d;
            rem_q      <= rem_d;
            awlen_q    <= awlen_d;
            issued_q   <= issued_d;
            wbeat_q    <= wbeat_d;
            err_q      <= err_d;
        end
    end

    // Tags each BRAM read; the oldest tag marks the cycle its data is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= '0;
        end else begin
            rd_vld_q[0] <= w_issue;
            for (int i = 1; i < BRAM_RD_LAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vrf_bram2axi_store.sv
`default_nettype none
// ============================================================================
// tb_vrf_bram2axi_store : table-driven bench with AW/W scoreboards for the
//                         VRF store engine.
// Revision: 1.0
// ============================================================================
module tb_vrf_bram2axi_store;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [9:0]   src_bram_addr;
    logic [35:0]  dst_axi_addr;
    logic [14:0]  byte_to_transfer;
    logic         busy, done, err;
    logic         bram_en;
    logic [9:0]   bram_addr;
    logic [511:0] bram_dout;
    logic [35:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst;
    logic         m_axi_awvalid, m_axi_awready;
    logic [511:0] m_axi_wdata;
    logic [63:0]  m_axi_wstrb;
    logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]   m_axi_bresp;
    logic         m_axi_bvalid, m_axi_bready;

    always #5 clk = ~clk;

    vrf_bram2axi_store dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .src_bram_addr    (src_bram_addr),
        .dst_axi_addr     (dst_axi_addr),
        .byte_to_transfer (byte_to_transfer),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .bram_en          (bram_en),
        .bram_addr        (bram_addr),
        .bram_dout        (bram_dout),
        .m_axi_awaddr     (m_axi_awaddr),
        .m_axi_awlen      (m_axi_awlen),
        .m_axi_awsize     (m_axi_awsize),
        .m_axi_awburst    (m_axi_awburst),
        .m_axi_awvalid    (m_axi_awvalid),
        .m_axi_awready    (m_axi_awready),
        .m_axi_wdata      (m_axi_wdata),
        .m_axi_wstrb      (m_axi_wstrb),
        .m_axi_wlast      (m_axi_wlast),
        .m_axi_wvalid     (m_axi_wvalid),
        .m_axi_wready     (m_axi_wready),
        .m_axi_bresp      (m_axi_bresp),
        .m_axi_bvalid     (m_axi_bvalid),
        .m_axi_bready     (m_axi_bready)
    );

    typedef struct {
        logic [9:0]  src;
        logic [35:0] dst;
        logic [14:0] btt;
        bit          wrnd;
        bit          bad_first;
        bit          exp_err;
        int          exp_naw;
        int          exp_beats;
    } vec_t;

    typedef struct {
        logic [35:0] addr;
        logic [7:0]  len;
    } aw_t;

    typedef struct {
        logic [511:0] data;
        bit           last;
    } w_t;

    aw_t  exp_aw[$];
    w_t   exp_w[$];
    vec_t vecs[8];

    int errors = 0;
    int checks = 0;
    int ncyc = 0;
    int aw_cnt, wbeats, bram_cnt, done_cnt, done_cyc, first_aw, last_b, t_start;
    int wlast_cnt = 0;
    int b_hs_cnt  = 0;
    int bad_idx   = -1;
    bit w_rand    = 1'b0;
    bit done_err, done_busy;

    function automatic logic [511:0] word(input logic [9:0] a);
        logic [511:0] w;
        for (int i = 0; i < 16; i++) begin
            w[i*32 +: 32] = {a, 6'(i), 16'hC0DE};
        end
        return w;
    endfunction

    // BRAM with two-cycle read latency
    logic       p1_en;
    logic [9:0] p1_addr;
    always @(posedge clk) begin
        p1_en   <= bram_en;
        p1_addr <= bram_addr;
        if (p1_en) bram_dout <= word(p1_addr);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    // Called once per negedge: scoreboards AW/W handshakes, logs B/done events.
    task automatic sample();
        aw_t ea;
        w_t  ew;
        ncyc++;
        if (bram_en) bram_cnt++;
        if (m_axi_awvalid && first_aw < 0) first_aw = ncyc;
        if (m_axi_awvalid && m_axi_awready) begin
            aw_cnt++;
            if (exp_aw.size() == 0) begin
                chk("aw_unexpected", 64'(m_axi_awaddr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                ea = exp_aw.pop_front();
                chk("awaddr", 64'(m_axi_awaddr), 64'(ea.addr));
                chk("awlen", 64'(m_axi_awlen), 64'(ea.len));
                chk("awsize_burst", 64'({m_axi_awsize, m_axi_awburst}), 64'({3'b110, 2'b01}));
            end
        end
        if (m_axi_wvalid && m_axi_wready) begin
            wbeats++;
            if (m_axi_wlast) wlast_cnt++;
            if (exp_w.size() == 0) begin
                chk("w_unexpected", m_axi_wdata[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                ew = exp_w.pop_front();
                chk("wdata_lo", m_axi_wdata[63:0], ew.data[63:0]);
                chk("wdata_hi", m_axi_wdata[511:448], ew.data[511:448]);
                chk("wlast", 64'(m_axi_wlast), 64'(ew.last));
                chk("wstrb", m_axi_wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
            end
        end
        if (m_axi_bvalid && m_axi_bready) begin
            b_hs_cnt++;
            last_b = ncyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc  = ncyc;
            done_err  = err;
            done_busy = busy;
        end
    endtask

    // AXI slave: ready generation and one B response per completed burst.
    initial begin
        int b_given;
        b_given       = 0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            m_axi_awready = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi_wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axi_bvalid) begin
                if (b_hs_cnt > b_given) begin
                    b_given++;
                    m_axi_bvalid = 1'b0;
                end
            end else if (b_given < wlast_cnt) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (b_given == bad_idx) ? 2'b10 : 2'b00;
            end
        end
    end

    task automatic push_expected(input vec_t v);
        int          rem, room, n;
        logic [35:0] addr;
        logic [9:0]  ba;
        aw_t         a;
        w_t          w;
        if (v.btt == 0 || v.btt[5:0] != 0 || v.dst[5:0] != 0) return;
        rem  = int'(v.btt) / 64;
        addr = v.dst;
        ba   = v.src;
        while (rem > 0) begin
            room   = (4096 - int'(addr[11:0])) / 64;
            n      = (rem < room) ? rem : room;
            a.addr = addr;
            a.len  = 8'(n - 1);
            exp_aw.push_back(a);
            for (int k = 0; k < n; k++) begin
                w.data = word(ba);
                w.last = (k == n - 1);
                exp_w.push_back(w);
                ba = ba + 10'd1;
            end
            addr = addr + 36'(n * 64);
            rem  = rem - n;
        end
    endtask

    task automatic clear_counts();
        aw_cnt = 0; wbeats = 0; bram_cnt = 0; done_cnt = 0;
        done_cyc = -1; first_aw = -1; last_b = -1;
    endtask

    task automatic issue_start(input vec_t v);
        @(posedge clk);
        #1;
        src_bram_addr    = v.src;
        dst_axi_addr     = v.dst;
        byte_to_transfer = v.btt;
        start            = 1'b1;
        @(negedge clk);
        sample();
        t_start = ncyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        sample();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        clear_counts();
        push_expected(v);
        w_rand  = v.wrnd;
        bad_idx = v.bad_first ? b_hs_cnt : -1;
        issue_start(v);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            sample();
            n++;
        end
        if (done_cnt == 0) chk({tag, "_done_timeout"}, 64'd0, 64'd1);
        chk({tag, "_err"}, 64'(done_err), 64'(v.exp_err));
        chk({tag, "_busy_at_done"}, 64'(done_busy), 64'd0);
        chk({tag, "_aw_count"}, 64'(aw_cnt), 64'(v.exp_naw));
        chk({tag, "_w_beats"}, 64'(wbeats), 64'(v.exp_beats));
        chk({tag, "_aw_left"}, 64'(exp_aw.size()), 64'd0);
        chk({tag, "_w_left"}, 64'(exp_w.size()), 64'd0);
        chk({tag, "_bram_reads"}, 64'(bram_cnt), 64'(v.exp_beats));
        if (v.exp_naw == 0) begin
            chk({tag, "_done_latency"}, 64'(done_cyc - t_start), 64'd2);
        end else begin
            chk({tag, "_aw_latency"}, 64'(first_aw - t_start), 64'd2);
            chk({tag, "_b_to_done"}, 64'(done_cyc - last_b), 64'd1);
        end
        repeat (4) begin
            @(negedge clk);
            sample();
        end
        chk({tag, "_single_done"}, 64'(done_cnt), 64'd1);
        w_rand = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, 64'({busy, done, err, bram_en, m_axi_awvalid,
                                m_axi_wvalid, m_axi_wlast, m_axi_bready}), 64'd0);
        chk({tag, "_bram_addr"}, 64'(bram_addr), 64'd0);
        chk({tag, "_awaddr"}, 64'(m_axi_awaddr), 64'd0);
        chk({tag, "_awlen"}, 64'(m_axi_awlen), 64'd0);
    endtask

    function automatic vec_t mk(input logic [9:0] s, input logic [35:0] d, input logic [14:0] b,
                                input bit wr, input bit bad, input bit e, input int naw, input int nb);
        vec_t v;
        v.src = s; v.dst = d; v.btt = b; v.wrnd = wr; v.bad_first = bad;
        v.exp_err = e; v.exp_naw = naw; v.exp_beats = nb;
        return v;
    endfunction

    initial begin
        int n;
        vecs[0] = mk(10'h010, 36'h1000, 15'd128,  1'b0, 1'b0, 1'b0, 1, 2);
        vecs[1] = mk(10'h020, 36'h0FC0, 15'd256,  1'b0, 1'b0, 1'b0, 2, 4);
        vecs[2] = mk(10'h000, 36'h0000, 15'd8192, 1'b1, 1'b0, 1'b0, 2, 128);
        vecs[3] = mk(10'h005, 36'h2000, 15'd0,    1'b0, 1'b0, 1'b0, 0, 0);
        vecs[4] = mk(10'h005, 36'h2000, 15'd100,  1'b0, 1'b0, 1'b1, 0, 0);
        vecs[5] = mk(10'h005, 36'h1010, 15'd64,   1'b0, 1'b0, 1'b1, 0, 0);
        vecs[6] = mk(10'h3FE, 36'h1F80, 15'd256,  1'b0, 1'b1, 1'b1, 2, 4);
        vecs[7] = mk(10'h100, 36'h2000, 15'd192,  1'b0, 1'b0, 1'b0, 1, 3);

        rst = 1'b1; start = 1'b0;
        src_bram_addr = '0; dst_axi_addr = '0; byte_to_transfer = '0;
        clear_counts();
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample();
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        sample();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort a long transfer partway through its first burst.
        clear_counts();
        push_expected(vecs[2]);
        w_rand = 1'b1;
        issue_start(vecs[2]);
        n = 0;
        while (wbeats < 5 && n < 2000) begin
            @(negedge clk);
            sample();
            n++;
        end
        chk("abort_reached_data", 64'(wbeats >= 5), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        rst = 1'b0;
        w_rand = 1'b0;
        @(negedge clk);
        sample();
        check_reset_outputs("abort");
        exp_aw.delete();
        exp_w.delete();
        clear_counts();
        repeat (3) begin
            @(negedge clk);
            sample();
        end
        chk("abort_no_done", 64'(done_cnt), 64'd0);

        run_vec(vecs[0], "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
